dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32 pipeline. It receives load and store requests from the memory-access stage over a valid/ready handshake and returns read data with a one-cycle response strobe. It serves word RAM, a memory-mapped LED register and a read-only cycle counter. It replaces the combinational data-memory path, so the memory-access stage can stall on `req_ready`.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit RAM words; must be a power of two.
- `LED_ADDR`, default 32'h8000_0000: address of the LED register.
- `CNT_ADDR`, default 32'h8000_0004: address of the cycle counter.

Ports (clock and reset first):
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: a request is present.
- `req_ready`, output, 1: the responder can accept a request.
- `req_write`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store data.
- `req_be`, input, 4: byte-lane enables; bit n enables byte n.
- `rsp_valid`, output, 1: single-cycle response strobe.
- `rsp_rdata`, output, 32: load data; 0 for stores and errors.
- `rsp_err`, output, 1: access fault, qualified by `rsp_valid`.
- `led`, output, 16: LED register, bits [15:0].

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`. `req_ready` is 1 only in state IDLE.
- Requests are never queued. Exactly one response is produced per accepted request.
- Address decode:
  - RAM: `req_addr < DEPTH_WORDS*4`.
  - LED: `req_addr == LED_ADDR`.
  - CNT: `req_addr == CNT_ADDR`.
  - Anything else is unmapped.
- Error cases: an access is an error when any of the following holds. Errors have no side effects.
  - `req_addr[1:0] != 0`.
  - The address is unmapped.
  - The access is a store to CNT.
- RAM store: bytes whose `req_be` bit is set are updated; other bytes are unchanged. `req_be == 0` is a legal no-op store with `rsp_err = 0`.
- RAM load: returns the full word. `req_be` is ignored; the memory-access stage handles byte/half extraction.
- LED store: `led` takes `req_wdata[15:0]`, masked by `req_be[1:0]`. LED load returns {16'h0, led}.
- CNT load: returns the free-running 32-bit counter value sampled at the acceptance edge. The counter wraps from FFFF_FFFF to 0.
- FSM states and transitions:
  - IDLE: on accept, RAM loads go to READ. All other accepts go to RESP.
  - READ: the RAM read is in flight; goes to RESP unconditionally.
  - RESP: `rsp_valid = 1`; goes to IDLE unconditionally.

## Timing
- Reset values: `req_ready = 0` while `rst = 0`, then 1 from the first cycle after release. `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`, `led = 0`, counter = 0, state = IDLE.
- RAM contents are not reset.
- Store, LED, CNT and error latency: acceptance edge T, then `rsp_valid` is high for the cycle after T. The write commits at edge T.
- RAM load latency: acceptance edge T, then READ for one cycle, then `rsp_valid` is high for the cycle after T+1.
- Throughput is one request per 2 cycles (stores) or 3 cycles (loads). `req_ready` is low in READ and RESP.
- `rsp_rdata` and `rsp_err` are valid only while `rsp_valid = 1` and return to 0 when it falls.
- Read after write: a load to an address stored by the previous request returns the new data, because the write has committed before the load is accepted.
- Reset asserted mid-operation: the FSM returns immediately to IDLE and `rsp_valid` drops. The pending request gets no response. A RAM write already committed at an earlier edge persists.
- The counter increments every cycle outside reset, including during RESP.

## Structure
- Shared package `mem_map_pkg` holds:
  - `LED_ADDR` and `CNT_ADDR` defaults.
  - The RAM base address.
  - The FSM state encoding {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2}.
- Sub-module `dmem_ram`: single-port synchronous RAM with a registered read port and byte-enable write, `DEPTH_WORDS` x 32.
- Decode, the FSM, the LED register and the counter live in `dmem_responder`.

## Test plan
- Reset: hold `rst = 0` for 3 cycles, then release -> `led = 0`, `rsp_valid = 0`, `req_ready = 1` from the first cycle after release; a CNT load issued 5 cycles later returns a small nonzero value that grows by 2-3 per back-to-back read.
- RAM store then load: store 0xDEADBEEF at 0x10 with be = 4'hF, then store 0x000000AA at 0x10 with be = 4'h1 -> a load of 0x10 returns 0xDEADBEAA. The load `rsp_valid` comes 2 cycles after acceptance; the stores' `rsp_valid` comes 1 cycle after.
- LED: store 0x1234_5678 to 0x8000_0000 with be = 4'h3 -> `led = 16'h5678` on the cycle after acceptance; a load of the LED address returns 0x0000_5678.
- Errors, each -> `rsp_err = 1` with RAM and `led` unchanged:
  - load at 0x2, misaligned;
  - store at 0x4000_0000, unmapped;
  - store to 0x8000_0004, store to CNT.
- Back-to-back: hold `req_valid = 1` with 4 alternating stores and loads -> `req_ready` pattern is 1,0,(0),1 per request; there are exactly 4 `rsp_valid` pulses, in order.
- Reset mid-load: drive `rst = 0` during READ -> no `rsp_valid`; after release, the next load of the same address returns the last committed data.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants, FSM encoding and request bundle for the
// data-memory responder.
package mem_map_pkg;

    localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR_DFLT = 32'h8000_0000;
    localparam logic [31:0] CNT_ADDR_DFLT = 32'h8000_0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_LED,
        TGT_CNT,
        TGT_NONE
    } target_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    // Map a byte address onto one of the served targets. The RAM window is
    // tested as an offset from its base so a nonzero base also works.
    function automatic target_t decode_target(
        input logic [31:0] addr,
        input logic [31:0] ram_bytes,
        input logic [31:0] led_addr,
        input logic [31:0] cnt_addr
    );
        target_t t;
        t = TGT_NONE;
        if ((addr - RAM_BASE) < ram_bytes) t = TGT_RAM;
        else if (addr == led_addr)         t = TGT_LED;
        else if (addr == cnt_addr)         t = TGT_CNT;
        return t;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: byte-enabled write, registered read, no reset.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Byte-lane write and registered read share the one address port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][b] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request side, one-cycle response
// strobe, serving word RAM, an LED register and a free-running counter.
module dmem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] LED_ADDR    = LED_ADDR_DFLT,
    parameter logic [31:0] CNT_ADDR    = CNT_ADDR_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] led
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

    state_t      state, state_nxt;
    dmem_req_t   req;
    target_t     tgt;
    logic        accept, misaligned, err;
    logic        ram_we, ram_re;
    logic [31:0] ram_off, ram_rdata;
    logic [31:0] cnt;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic [15:0] led_q;
    logic        unused_off_bits;

    assign req = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};

    // Ready only in IDLE and never while reset is held.
    assign req_ready = rst && (state == IDLE);
    assign accept    = req_valid && req_ready;

    // Decode and fault classification; faulting accesses touch nothing.
    assign tgt        = decode_target(req.addr, RAM_BYTES, LED_ADDR, CNT_ADDR);
    assign misaligned = |req.addr[1:0];
    assign err        = misaligned || (tgt == TGT_NONE) || (req.write && tgt == TGT_CNT);

    assign ram_we  = accept &&  req.write && !err && (tgt == TGT_RAM);
    assign ram_re  = accept && !req.write && !err && (tgt == TGT_RAM);
    assign ram_off = req.addr - RAM_BASE;
    assign unused_off_bits = ^{ram_off[31:AW+2], ram_off[1:0]};

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_off[AW+1:2]),
        .wdata (req.wdata),
        .be    (req.be),
        .rdata (ram_rdata)
    );

    // State register; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and response strobe. Only valid RAM loads need the READ
    // cycle to wait for the registered RAM output.
    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: if (accept) state_nxt = ram_re ? READ : RESP;
            READ: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data and error are forced to zero outside the response strobe.
    assign rsp_rdata = rsp_valid ? rsp_data_q : '0;
    assign rsp_err   = rsp_valid & rsp_err_q;
    assign led       = led_q;

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt + 32'd1;
    end

    // Response capture: LED/CNT/error results at acceptance, RAM data in READ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            rsp_err_q  <= err;
            rsp_data_q <= '0;
            if (!err && !req.write) begin
                case (tgt)
                    TGT_LED: rsp_data_q <= {16'h0, led_q};
                    TGT_CNT: rsp_data_q <= cnt;
                    default: rsp_data_q <= '0;
                endcase
            end
        end else if (state == READ) begin
            rsp_data_q <= ram_rdata;
        end
    end

    // LED register: low two byte lanes of a store, committed at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
        end else if (accept && req.write && !err && (tgt == TGT_LED)) begin
            if (req.be[0]) led_q[7:0]  <= req.wdata[7:0];
            if (req.be[1]) led_q[15:8] <= req.wdata[15:8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses
// computed from a memory-map model; a monitor pops and compares.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] LED_A = 32'h8000_0000;
    localparam logic [31:0] CNT_A = 32'h8000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] led;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LED_ADDR    (LED_A),
        .CNT_ADDR    (CNT_A)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .led       (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        bit          chk_lat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_rsp = 0;
    int          cyc = 0;
    logic [31:0] cnt_m = '0;
    logic [31:0] ram_m [DEPTH];
    logic [15:0] led_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference cycle count: zero in reset, +1 per clock outside it.
    always @(posedge clk or negedge rst) begin
        if (!rst) cnt_m <= '0;
        else      cnt_m <= cnt_m + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %h err %0d with nothing outstanding", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                check({e.name, " err"}, 32'(rsp_err), 32'(e.err));
                check({e.name, " rdata"}, rsp_rdata, e.rdata);
                check({e.name, " led"}, 32'(led), 32'(led_m));
                if (e.chk_lat) check({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end else begin
            check("idle_rsp_zero", {rsp_rdata[31:1], rsp_rdata[0] | rsp_err}, 32'h0);
        end
    end

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Present one request (called at a negedge), wait for acceptance, model it.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int exp_wait);
        exp_t e;
        bit   is_ram, is_led, is_cnt, err;
        int   waited = 0;
        int   idx;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: addr %h never accepted, required within 20 cycles", a);
            req_valid = 1'b0;
            return;
        end
        if (exp_wait >= 0) check($sformatf("ready_wait@%h", a), 32'(waited), 32'(exp_wait));
        is_ram = a < 32'(DEPTH * 4);
        is_led = a == LED_A;
        is_cnt = a == CNT_A;
        err    = (a[1:0] != 2'b00) || !(is_ram || is_led || is_cnt) || (wr && is_cnt);
        idx    = int'(a >> 2);
        e.name    = $sformatf("%s@%h", wr ? "st" : "ld", a);
        e.err     = err;
        e.rdata   = '0;
        e.acc     = cyc + 1;
        e.chk_lat = !err;
        e.lat     = (!err && !wr && is_ram) ? 2 : 1;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (is_ram && be[b])        ram_m[idx][8*b +: 8] = wd[8*b +: 8];
                    if (is_led && b < 2 && be[b]) led_m[8*b +: 8]    = wd[8*b +: 8];
                end
            end else if (is_ram) e.rdata = ram_m[idx];
            else if (is_led)     e.rdata = {16'h0, led_m};
            else                 e.rdata = cnt_m;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            6:       a = 32'hFFC;
            7:       a = LED_A;
            8:       a = CNT_A;
            9: begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h1000;
                    1:       a = 32'h4000_0000;
                    2:       a = LED_A + 32'd8;
                    default: a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(1, 3));
                endcase
            end
            default: a = 32'($urandom_range(0, 15) * 4);
        endcase
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp0;
        int waited;
        // Reset held for 3 cycles.
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_led", 32'(led), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'h1);
        check("led_after_release", 32'(led), 32'h0);
        repeat (3) @(negedge clk);
        issue(1'b0, CNT_A, '0, 4'hF, 0);
        issue(1'b0, CNT_A, '0, 4'hF, 1);
        issue(1'b0, CNT_A, '0, 4'hF, 1);
        idle(2);

        // Give the RAM words the random phase touches known contents.
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, -1);
        issue(1'b1, 32'hFFC, $urandom, 4'hF, -1);
        idle(2);

        // Byte-enable merge and read-after-write.
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, -1);
        issue(1'b1, 32'h10, 32'h0000_00AA, 4'h1, 1);
        issue(1'b0, 32'h10, '0, 4'h0, 1);
        idle(3);

        // LED store masked to low lanes, then read back.
        issue(1'b1, LED_A, 32'h1234_5678, 4'h3, -1);
        check("led_after_store", 32'(led), 32'h5678);
        issue(1'b0, LED_A, '0, 4'hF, 1);
        idle(2);

        // Faults and boundaries.
        issue(1'b0, 32'h2, '0, 4'hF, -1);
        issue(1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, -1);
        issue(1'b1, CNT_A, 32'h1111_1111, 4'hF, -1);
        issue(1'b1, 32'h1000, 32'h2222_2222, 4'hF, -1);
        issue(1'b1, 32'h20, 32'h3333_3333, 4'h0, -1);
        issue(1'b0, 32'h20, '0, 4'hF, -1);
        issue(1'b0, 32'hFFC, '0, 4'hF, -1);
        issue(1'b0, LED_A, '0, 4'hF, -1);
        idle(3);

        // Back-to-back with valid held high.
        rsp0 = n_rsp;
        issue(1'b1, 32'h24, $urandom, 4'hF, 0);
        issue(1'b0, 32'h24, '0, 4'hF, 1);
        issue(1'b1, 32'h28, $urandom, 4'hF, 2);
        issue(1'b0, 32'h28, '0, 4'hF, 1);
        idle(4);
        check("b2b_rsp_count", 32'(n_rsp - rsp0), 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom), -1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        // Reset during the READ cycle of a load: no response, data kept.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_be    = 4'hF;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("midreset_accept", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (2) @(negedge clk);
        check("midreset_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        led_m = '0;
        @(negedge clk);
        check("midreset_led", 32'(led), 32'h0);
        issue(1'b0, 32'h10, '0, 4'hF, 0);
        issue(1'b0, LED_A, '0, 4'hF, -1);
        issue(1'b0, CNT_A, '0, 4'hF, -1);

        // Drain.
        req_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("outstanding_at_end", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
